// File: rtl/id_decode_stage_pkg.sv
// Shared definitions for the ID stage: sizes, instruction field positions,
// opcode/funct constants and ALU operation codes.
package id_decode_stage_pkg;

    localparam int DSIZE = 32;
    localparam int ASIZE = 5;
    localparam int ISIZE = 32;

    // Instruction field bit positions
    localparam int OP_HI    = 31;
    localparam int OP_LO    = 26;
    localparam int RS_LO    = 21;
    localparam int RT_LO    = 16;
    localparam int RD_LO    = 11;
    localparam int FUNCT_HI = 5;
    localparam int IMM_HI   = 15;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_ADDI  = 6'h08,
        OP_SLTI  = 6'h0A,
        OP_ANDI  = 6'h0C,
        OP_ORI   = 6'h0D,
        OP_XORI  = 6'h0E
    } opcode_t;

    typedef enum logic [5:0] {
        F_SLL = 6'h00,
        F_SRL = 6'h02,
        F_ADD = 6'h20,
        F_SUB = 6'h22,
        F_AND = 6'h24,
        F_OR  = 6'h25,
        F_XOR = 6'h26,
        F_SLT = 6'h2A
    } funct_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SLT = 3'd5,
        ALU_SLL = 3'd6,
        ALU_SRL = 3'd7
    } alu_op_t;

endpackage

// File: rtl/id_decode_stage_reg_file.sv
// 2R1W architectural register file.
//   clk, rst        : clock, synchronous active-high reset (clears all entries)
//   raddr1/raddr2   : asynchronous read addresses -> rdata1/rdata2
//   wen/waddr/wdata : synchronous write port (posedge clk)
// r0 always reads 0 and ignores writes. A write in flight this cycle is
// forwarded to a matching read port (write-through bypass).
module reg_file
    import id_decode_stage_pkg::*;
#(
    parameter int DSIZE = id_decode_stage_pkg::DSIZE,
    parameter int ASIZE = id_decode_stage_pkg::ASIZE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ASIZE-1:0] raddr1,
    input  logic [ASIZE-1:0] raddr2,
    output logic [DSIZE-1:0] rdata1,
    output logic [DSIZE-1:0] rdata2,
    input  logic             wen,
    input  logic [ASIZE-1:0] waddr,
    input  logic [DSIZE-1:0] wdata
);

    logic [DSIZE-1:0] mem [2**ASIZE];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < 2**ASIZE; i++) begin
                mem[i] <= '0;
            end
        end else if (wen && (waddr != '0)) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata1 = mem[raddr1];
        rdata2 = mem[raddr2];
        if (wen && (waddr == raddr1)) rdata1 = wdata;
        if (wen && (waddr == raddr2)) rdata2 = wdata;
        if (raddr1 == '0) rdata1 = '0;
        if (raddr2 == '0) rdata2 = '0;
    end

endmodule

// File: rtl/id_decode_stage.sv
// Instruction-decode stage of the IF/ID/EXE/WB pipeline.
//   clk, rst                  : clock, synchronous active-high reset
//   instr, instr_valid        : instruction from the IF/ID register
//   wb_wen/wb_waddr/wb_wdata  : register-file write from WB
//   aluop_cntrl, alusrc_cntrl : ALU control for EXE
//   rdata1, rdata2, sign_ex   : operands (rs, rt, sign-extended imm)
//   waddr, wen_cntrl          : destination and write enable (0 = bubble)
//   stall                     : hold PC and IF/ID this cycle
// Tracks the destination of the instruction in EXE and stalls one cycle on a
// read-after-write dependence; the following cycle the value comes from WB
// through the register-file bypass.
module id_decode_stage
    import id_decode_stage_pkg::*;
#(
    parameter int DSIZE = id_decode_stage_pkg::DSIZE,
    parameter int ASIZE = id_decode_stage_pkg::ASIZE,
    parameter int ISIZE = id_decode_stage_pkg::ISIZE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ISIZE-1:0] instr,
    input  logic             instr_valid,
    input  logic             wb_wen,
    input  logic [ASIZE-1:0] wb_waddr,
    input  logic [DSIZE-1:0] wb_wdata,
    output logic [2:0]       aluop_cntrl,
    output logic             alusrc_cntrl,
    output logic [DSIZE-1:0] rdata1,
    output logic [DSIZE-1:0] rdata2,
    output logic [DSIZE-1:0] sign_ex,
    output logic [ASIZE-1:0] waddr,
    output logic             wen_cntrl,
    output logic             stall
);

    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic [ASIZE-1:0] rs, rt, rd;
    logic [15:0]      imm;
    logic             unused_shamt;

    assign opcode       = instr[OP_HI:OP_LO];
    assign funct        = instr[FUNCT_HI:0];
    assign rs           = instr[RS_LO +: ASIZE];
    assign rt           = instr[RT_LO +: ASIZE];
    assign rd           = instr[RD_LO +: ASIZE];
    assign imm          = instr[IMM_HI:0];
    assign unused_shamt = ^instr[10:6];

    logic [DSIZE-1:0] rf_rdata1, rf_rdata2;

    reg_file #(.DSIZE(DSIZE), .ASIZE(ASIZE)) u_reg_file (
        .clk    (clk),
        .rst    (rst),
        .raddr1 (rs),
        .raddr2 (rt),
        .rdata1 (rf_rdata1),
        .rdata2 (rf_rdata2),
        .wen    (wb_wen),
        .waddr  (wb_waddr),
        .wdata  (wb_wdata)
    );

    logic [ASIZE-1:0] ex_waddr;
    logic             ex_wen;

    alu_op_t          dec_aluop;
    logic             dec_alusrc;
    logic [ASIZE-1:0] dec_waddr;
    logic             dec_legal;
    logic             hazard;
    logic             issue;

    always_comb begin
        dec_aluop  = ALU_ADD;
        dec_alusrc = 1'b0;
        dec_waddr  = rt;
        dec_legal  = 1'b1;
        case (opcode)
            OP_RTYPE: begin
                dec_waddr = rd;
                case (funct)
                    F_ADD:   dec_aluop = ALU_ADD;
                    F_SUB:   dec_aluop = ALU_SUB;
                    F_AND:   dec_aluop = ALU_AND;
                    F_OR:    dec_aluop = ALU_OR;
                    F_XOR:   dec_aluop = ALU_XOR;
                    F_SLT:   dec_aluop = ALU_SLT;
                    F_SLL:   dec_aluop = ALU_SLL;
                    F_SRL:   dec_aluop = ALU_SRL;
                    default: dec_legal = 1'b0;
                endcase
            end
            OP_ADDI: begin dec_aluop = ALU_ADD; dec_alusrc = 1'b1; end
            OP_ANDI: begin dec_aluop = ALU_AND; dec_alusrc = 1'b1; end
            OP_ORI:  begin dec_aluop = ALU_OR;  dec_alusrc = 1'b1; end
            OP_XORI: begin dec_aluop = ALU_XOR; dec_alusrc = 1'b1; end
            OP_SLTI: begin dec_aluop = ALU_SLT; dec_alusrc = 1'b1; end
            default: dec_legal = 1'b0;
        endcase
    end

    // rt is only a source operand for R-type; I-type rt is the destination.
    assign hazard = !rst && instr_valid && ex_wen && (ex_waddr != '0) &&
                    ((ex_waddr == rs) || ((opcode == OP_RTYPE) && (ex_waddr == rt)));
    assign issue  = !rst && instr_valid && !hazard && dec_legal;

    always_comb begin
        aluop_cntrl  = ALU_ADD;
        alusrc_cntrl = 1'b0;
        rdata1       = '0;
        rdata2       = '0;
        sign_ex      = '0;
        waddr        = '0;
        wen_cntrl    = 1'b0;
        stall        = hazard;
        if (issue) begin
            aluop_cntrl  = dec_aluop;
            alusrc_cntrl = dec_alusrc;
            rdata1       = rf_rdata1;
            rdata2       = rf_rdata2;
            sign_ex      = {{(DSIZE-16){imm[15]}}, imm};
            waddr        = dec_waddr;
            wen_cntrl    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_waddr <= '0;
            ex_wen   <= 1'b0;
        end else begin
            ex_waddr <= waddr;
            ex_wen   <= wen_cntrl;
        end
    end

endmodule
